psum_drain: RTL and testbench
=============================

# psum_drain

Column-output drain stage directly downstream of the systolic MAC array. It captures the COLS skewed partial-sum outputs leaving the bottom row and de-skews them into one aligned row. Each 40-bit Q(26.14) partial sum is requantized to the 16-bit Q(8.8) activation format, and rows are buffered in an output FIFO behind a valid/ready handshake. A small FSM counts rows per tile and pulses completion once the tile has fully drained.

## Interface
- COLS, 4, number of array columns drained
- P_BITWIDTH, 40, partial-sum width (signed two's complement)
- P_FRAC_BIT, 14, partial-sum fraction bits
- A_BITWIDTH, 16, output activation width (signed)
- A_FRAC_BIT, 8, output fraction bits
- FIFO_DEPTH, 8, output FIFO entries (power of two, ≥4)
- ROW_CNT_W, 8, width of tile row count
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  begin a tile; sampled only in IDLE
- rows_i  in  ROW_CNT_W  rows in the tile, sampled with start_i
- p_valid_i  in  COLS  per-column valid; column c asserts one cycle after column c-1
- p_i  in  COLS*P_BITWIDTH  column partial sums, column c at bits [c*P_BITWIDTH +: P_BITWIDTH]
- out_valid_o  out  1  FIFO head valid
- out_ready_i  in  1  consumer accepts head when high with out_valid_o
- out_data_o  out  COLS*A_BITWIDTH  requantized row, same packing as p_i
- almost_full_o  out  1  FIFO occupancy ≥ FIFO_DEPTH-3
- overflow_o  out  1  sticky: a row was dropped on full FIFO
- skew_err_o  out  1  sticky: aligned column valids disagreed
- done_o  out  1  one-cycle tile-complete pulse

## Operation
- De-skew: column c passes through COLS-c registers (column COLS-1 gets 1). Data and valid are delayed together.
- Aligned row valid is delayed column-0 valid. If any aligned column valid differs from it, skew_err_o is set; the row is still processed using column-0 valid.
- Requantize per column, registered (1 stage): add 1<<(P_FRAC_BIT-A_FRAC_BIT-1), arithmetic shift right by P_FRAC_BIT-A_FRAC_BIT (6), saturate to [-2^(A_BITWIDTH-1), 2^(A_BITWIDTH-1)-1].
- Commit: a valid requantized row is pushed to the FIFO.
  - If the FIFO is full and there is no pop in the same cycle, the row is dropped and overflow_o is set.
  - Push while full with a simultaneous pop succeeds.
- FIFO is first-word-fall-through; a pop happens when out_valid_o && out_ready_i.
- FSM states:
  - IDLE: on start_i, latch rows_i. Go to FLUSH if rows_i==0, otherwise DRAIN with the row counter cleared. Committed rows in IDLE are still pushed but not counted.
  - DRAIN: count every commit, including dropped rows. On the commit that brings count to rows_i, go to FLUSH.
  - FLUSH: wait until the FIFO is empty and the pipeline holds no valid row, then go to DONE.
  - DONE: done_o=1 for one cycle, then IDLE.
- start_i outside IDLE is ignored.

## Timing
- Reset values: out_valid_o=0, out_data_o=0, almost_full_o=0, overflow_o=0, skew_err_o=0, done_o=0. FSM goes to IDLE; FIFO, de-skew and quant pipeline valids are cleared.
- Latency: row whose column COLS-1 element is presented in cycle t gives out_valid_o in cycle t+3 (de-skew t+1, quant t+2, FIFO head t+3) when the FIFO is empty.
- Throughput: one row per cycle sustained with out_ready_i held high.
- out_data_o holds stable while out_valid_o=1 and out_ready_i=0.
- rst mid-tile: in-flight and buffered rows are discarded and the sticky flags cleared. The next cycle is IDLE.
- done_o asserts no earlier than the cycle after the last row's pop.

## Configuration
- PSUM_DRAIN_RELU_EN defined: after saturation, negative columns are forced to 0 in the quant stage; latency is unchanged.
- Not defined: signed saturated values pass through unmodified.

## Structure
- Shared package holds:
  - the drain FSM state enum (IDLE, DRAIN, FLUSH, DONE);
  - a requant shift constant derived from P_FRAC_BIT/A_FRAC_BIT;
  - saturation bound constants shared with other requantizing stages.
- One sub-module: psum_fifo (parameterized FWFT sync FIFO with count, full, empty). De-skew, quant and FSM stay in psum_drain.

## Test plan
- Single skewed row, p = 1<<14 in all columns (1.0), FIFO empty, ready=1 -> out_data_o = 0x0100 per column, out_valid_o exactly at t+3.
- Rounding and saturation:
  - p = 0x20 -> 1 and p = 0x1F -> 0;
  - p = 1<<30 -> 0x7FFF and p = -(1<<30) -> 0x8000 (0x0000 with PSUM_DRAIN_RELU_EN).
- Backpressure: ready=0, push 9 rows with FIFO_DEPTH=8 -> 8 rows retained, overflow_o=1, almost_full_o high from occupancy 5. Release ready -> 8 rows out in order.
- Tile flow: start_i with rows_i=3, push 3 rows, ready=1 -> done_o single pulse after the third pop. rows_i=0 -> done_o two cycles after start_i.
- Skew fault: column 2 valid one cycle late -> skew_err_o=1 and stays set until rst.
- Reset mid-tile with 4 rows buffered -> next cycle out_valid_o=0, FSM in IDLE, flags cleared.

Source files
------------

// File: rtl/psum_drain_pkg.sv
// psum_drain_pkg: drain FSM states and requantization constants shared by requantizing stages
package psum_drain_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_FLUSH, ST_DONE} drain_st_e;
  localparam int PSUM_FRAC = 14;
  localparam int ACT_FRAC = 8;
  localparam int ACT_W = 16;
  function automatic int requant_shift(input int p_frac, input int a_frac);
    return p_frac - a_frac;
  endfunction
  localparam int REQ_SHIFT = requant_shift(PSUM_FRAC, ACT_FRAC);
  localparam longint ACT_SAT_MAX = (longint'(1) <<< (ACT_W - 1)) - 1;
  localparam longint ACT_SAT_MIN = -(longint'(1) <<< (ACT_W - 1));
endpackage

// File: rtl/psum_fifo.sv
// psum_fifo: first-word-fall-through synchronous FIFO with occupancy count
module psum_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [W-1:0]                 wdata_i,
  output logic [W-1:0]                 rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH):0]       count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign rdata_o = empty_o ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/psum_drain.sv
// psum_drain: de-skews systolic column outputs, requantizes Q26.14 -> Q8.8 into a FIFO, tracks tile rows.
// Optional PSUM_DRAIN_RELU_EN clamps negative requantized columns to zero.
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int COLS = 4,
  parameter int P_BITWIDTH = 40,
  parameter int P_FRAC_BIT = PSUM_FRAC,
  parameter int A_BITWIDTH = ACT_W,
  parameter int A_FRAC_BIT = ACT_FRAC,
  parameter int FIFO_DEPTH = 8,
  parameter int ROW_CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [ROW_CNT_W-1:0]         rows_i,
  input  logic [COLS-1:0]              p_valid_i,
  input  logic [COLS*P_BITWIDTH-1:0]   p_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [COLS*A_BITWIDTH-1:0]   out_data_o,
  output logic                         almost_full_o,
  output logic                         overflow_o,
  output logic                         skew_err_o,
  output logic                         done_o
);
  localparam int SH = requant_shift(P_FRAC_BIT, A_FRAC_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic signed [P_BITWIDTH:0] RND = (P_BITWIDTH+1)'(longint'(1) <<< (SH - 1));
  localparam logic signed [P_BITWIDTH:0] HI = (P_BITWIDTH+1)'(ACT_SAT_MAX);
  localparam logic signed [P_BITWIDTH:0] LO = (P_BITWIDTH+1)'(ACT_SAT_MIN);
  // One extra bit keeps the rounding add from wrapping at the positive extreme
  function automatic logic [A_BITWIDTH-1:0] rq(input logic signed [P_BITWIDTH-1:0] p);
    logic signed [P_BITWIDTH:0] s;
    s = ($signed({p[P_BITWIDTH-1], p}) + RND) >>> SH;
`ifdef PSUM_DRAIN_RELU_EN
    if (s < 0) s = '0;
`endif
    return s > HI ? HI[A_BITWIDTH-1:0] : s < LO ? LO[A_BITWIDTH-1:0] : s[A_BITWIDTH-1:0];
  endfunction
  logic [COLS-1:0] al_v, busy;
  logic [P_BITWIDTH-1:0] al_d [COLS];
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int D = COLS - c;
    logic [D-1:0] v_q;
    logic [P_BITWIDTH-1:0] d_q [D];
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= '0;
        for (int k = 0; k < D; k++) d_q[k] <= '0;
      end else begin
        v_q[0] <= p_valid_i[c];
        d_q[0] <= p_i[c*P_BITWIDTH +: P_BITWIDTH];
        for (int k = 1; k < D; k++) begin
          v_q[k] <= v_q[k-1];
          d_q[k] <= d_q[k-1];
        end
      end
    end
    assign al_v[c] = v_q[D-1];
    assign al_d[c] = d_q[D-1];
    assign busy[c] = |v_q;
  end
  logic q_valid_q, skew_q, ovf_q;
  logic [COLS*A_BITWIDTH-1:0] q_data_q, q_data_d;
  always_comb begin
    q_data_d = '0;
    for (int k = 0; k < COLS; k++) q_data_d[k*A_BITWIDTH +: A_BITWIDTH] = rq(al_d[k]);
  end
  logic full, empty, push, pop;
  logic [CW-1:0] count;
  assign pop = !empty && out_ready_i;
  assign push = q_valid_q && (!full || pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid_q <= 1'b0;
      q_data_q <= '0;
      skew_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_valid_q <= al_v[0];
      q_data_q <= q_data_d;
      skew_q <= skew_q | (|(al_v ^ {COLS{al_v[0]}}));
      ovf_q <= ovf_q | (q_valid_q && full && !pop);
    end
  end
  psum_fifo #(.W(COLS*A_BITWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .pop_i(pop),
    .wdata_i(q_data_q),
    .rdata_o(out_data_o),
    .full_o(full),
    .empty_o(empty),
    .count_o(count)
  );
  assign out_valid_o = !empty;
  assign almost_full_o = count >= CW'(FIFO_DEPTH - 3);
  assign overflow_o = ovf_q;
  assign skew_err_o = skew_q;
  drain_st_e state_q, state_d;
  logic [ROW_CNT_W-1:0] rows_q, rows_d, cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    rows_d = rows_q;
    cnt_d = cnt_q;
    case (state_q)
      ST_IDLE: if (start_i) begin
        rows_d = rows_i;
        cnt_d = '0;
        state_d = rows_i == '0 ? ST_FLUSH : ST_DRAIN;
      end
      // Dropped rows still count: the tile is defined by rows leaving the array
      ST_DRAIN: if (q_valid_q) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == rows_q) state_d = ST_FLUSH;
      end
      ST_FLUSH: if (empty && !q_valid_q && !(|busy)) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rows_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rows_q <= rows_d;
      cnt_q <= cnt_d;
    end
  end
  assign done_o = state_q == ST_DONE;
endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: randomized scoreboard bench for psum_drain against an arithmetic requant model
module tb_psum_drain;
  localparam int COLS = 4, PW = 40, AW = 16, DEPTH = 8, RW = 8;
  logic clk = 0, rst = 1, start_i = 0, out_ready_i = 0;
  logic [RW-1:0] rows_i = '0;
  logic [COLS-1:0] p_valid_i = '0;
  logic [COLS*PW-1:0] p_i = '0;
  logic out_valid_o, almost_full_o, overflow_o, skew_err_o, done_o;
  logic [COLS*AW-1:0] out_data_o;

  psum_drain dut (
    .clk(clk), .rst(rst), .start_i(start_i), .rows_i(rows_i),
    .p_valid_i(p_valid_i), .p_i(p_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .almost_full_o(almost_full_o), .overflow_o(overflow_o),
    .skew_err_o(skew_err_o), .done_o(done_o)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0, miscompares = 0;
  logic [COLS*AW-1:0] sb [$];
  logic [PW-1:0] rows_buf [16][COLS];
  int first_v_cyc = -1, last_pop_cyc = -1, done_cnt = 0, done_cyc = -1, t_last = 0;
  bit rand_ready = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] model_rq(input logic signed [PW-1:0] p);
    longint v;
    v = (longint'(p) + 32) >>> 6;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`ifdef PSUM_DRAIN_RELU_EN
    if (v < 0) v = 0;
`endif
    return AW'(v);
  endfunction

  function automatic logic [COLS*AW-1:0] row_exp(input int r);
    logic [COLS*AW-1:0] e;
    for (int c = 0; c < COLS; c++) e[c*AW +: AW] = model_rq(rows_buf[r][c]);
    return e;
  endfunction

  function automatic logic [PW-1:0] rand_p();
    logic signed [PW-1:0] x;
    int m;
    x = PW'({$urandom, $urandom});
    m = $urandom_range(0, 3);
    if (m == 0) x = x >>> 18;
    else if (m == 2) x = x >>> 16;
    else if (m == 3) x = {{(PW-8){x[7]}}, x[7:0]};
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready_i = 1'($urandom_range(0, 1));
  endtask

  // Row r enters column c at stream cycle r+c; column `late` slips one more cycle
  task automatic drive_stream(input int n, input int late);
    logic [COLS-1:0] pv;
    logic [COLS*PW-1:0] pd;
    int r;
    for (int j = 0; j < n + COLS - 1 + (late >= 0 ? 1 : 0); j++) begin
      pv = '0;
      pd = '0;
      for (int c = 0; c < COLS; c++) begin
        r = j - c - (c == late ? 1 : 0);
        if (r >= 0 && r < n) begin
          pv[c] = 1'b1;
          pd[c*PW +: PW] = rows_buf[r][c];
        end
      end
      p_valid_i = pv;
      p_i = pd;
      if (pv[COLS-1]) t_last = cyc;
      tick();
    end
    p_valid_i = '0;
    p_i = '0;
  endtask

  task automatic push_rows(input int n);
    for (int r = 0; r < n; r++) sb.push_back(row_exp(r));
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((sb.size() != 0 || out_valid_o) && k < 2000) begin
      tick();
      k++;
    end
    check("drain_in_time", 64'(k < 2000), 64'd1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid_o && first_v_cyc < 0) first_v_cyc = cyc;
      if (out_valid_o && out_ready_i) begin
        last_pop_cyc = cyc;
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL row: unexpected output %0h, none expected", out_data_o);
        end else check("row", out_data_o, sb.pop_front());
      end
    end
  end

  initial begin
    int n, k, s;
    repeat (3) tick();
    check("rst_valid", 64'(out_valid_o), 0);
    check("rst_data", out_data_o, 0);
    check("rst_afull", 64'(almost_full_o), 0);
    check("rst_ovf", 64'(overflow_o), 0);
    check("rst_skew", 64'(skew_err_o), 0);
    check("rst_done", 64'(done_o), 0);
    rst = 0;
    out_ready_i = 1;
    tick();
    // Single 1.0 row: latency and value
    for (int c = 0; c < COLS; c++) rows_buf[0][c] = 40'(1) << 14;
    check("model_one", row_exp(0), 64'h0100_0100_0100_0100);
    push_rows(1);
    first_v_cyc = -1;
    drive_stream(1, -1);
    repeat (4) tick();
    check("latency", 64'(first_v_cyc - t_last), 64'd3);
    // Rounding and saturation corners
    rows_buf[0][0] = 40'h20; rows_buf[0][1] = 40'h1F;
    rows_buf[0][2] = 40'(1) << 30; rows_buf[0][3] = -(40'(1) << 30);
    rows_buf[1][0] = -40'h20; rows_buf[1][1] = -40'h21;
    rows_buf[1][2] = 40'h7F_FFFF_FFFF; rows_buf[1][3] = 40'h80_0000_0000;
    push_rows(2);
    drive_stream(2, -1);
    wait_drain();
    // Randomized traffic with random backpressure, never exceeding FIFO capacity
    rand_ready = 1;
    repeat (80) begin
      n = $urandom_range(1, 3);
      k = 0;
      while (sb.size() + n > DEPTH && k < 1000) begin
        tick();
        k++;
      end
      check("space_in_time", 64'(k < 1000), 64'd1);
      for (int r = 0; r < n; r++)
        for (int c = 0; c < COLS; c++) rows_buf[r][c] = rand_p();
      push_rows(n);
      drive_stream(n, -1);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_ready = 0;
    out_ready_i = 1;
    wait_drain();
    check("no_ovf", 64'(overflow_o), 0);
    check("no_skew", 64'(skew_err_o), 0);
    // Tile of three rows
    done_cnt = 0;
    start_i = 1; rows_i = 3;
    tick();
    start_i = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < COLS; c++) rows_buf[r][c] = rand_p();
    push_rows(3);
    drive_stream(3, -1);
    wait_drain();
    repeat (6) tick();
    check("tile_done_cnt", 64'(done_cnt), 64'd1);
    check("done_after_pop", 64'(done_cyc > last_pop_cyc), 64'd1);
    // Backpressure: nine rows into eight entries
    out_ready_i = 0;
    for (int i = 0; i < 9; i++) begin
      for (int c = 0; c < COLS; c++) rows_buf[0][c] = 40'(i * 4 + c + 1) << 14;
      if (i < DEPTH) push_rows(1);
      drive_stream(1, -1);
      repeat (3) tick();
      check("afull", 64'(almost_full_o), 64'((i + 1) >= 5));
      check("ovf", 64'(overflow_o), 64'(i == 8));
    end
    out_ready_i = 1;
    wait_drain();
    check("ovf_sticky", 64'(overflow_o), 64'd1);
    rst = 1; sb.delete(); tick(); rst = 0;
    check("ovf_cleared", 64'(overflow_o), 0);
    // Skew fault followed by a buffered tile cut short by reset
    out_ready_i = 0;
    for (int c = 0; c < COLS; c++) rows_buf[0][c] = 40'(1) << 14;
    drive_stream(1, 2);
    repeat (3) tick();
    check("skew_set", 64'(skew_err_o), 64'd1);
    start_i = 1; rows_i = 5;
    tick();
    start_i = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < COLS; c++) rows_buf[r][c] = rand_p();
    drive_stream(3, -1);
    repeat (3) tick();
    check("skew_sticky", 64'(skew_err_o), 64'd1);
    check("buffered", 64'(out_valid_o), 64'd1);
    check("afull_4", 64'(almost_full_o), 0);
    rst = 1; sb.delete(); tick(); rst = 0;
    check("mid_rst_valid", 64'(out_valid_o), 0);
    check("mid_rst_data", out_data_o, 0);
    check("mid_rst_skew", 64'(skew_err_o), 0);
    check("mid_rst_afull", 64'(almost_full_o), 0);
    check("mid_rst_done", 64'(done_o), 0);
    // Empty tile straight from reset proves the FSM is idle
    done_cyc = -1;
    s = cyc;
    start_i = 1; rows_i = 0;
    tick();
    start_i = 0;
    repeat (6) tick();
    check("zero_tile_done", 64'(done_cyc - s), 64'd2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
